// File: rtl/enc_pkg.sv
// Shared types and helpers for the 4-line pending encoder.
// Contents:
//   N_LINES / IDX_W : number of request lines and width of an encoded index.
//   idx_t           : encoded line index (0..3).
//   line_vec_t      : one bit per request line.
//   onehot()        : index -> one-hot line vector (00->0001 ... 11->1000).
package enc_pkg;

  localparam int N_LINES = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [N_LINES-1:0] line_vec_t;

  function automatic line_vec_t onehot(input idx_t idx);
    onehot = line_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_pick_4.sv
// Combinational circular priority picker over 4 lines.
// Ports:
//   vec   in  4  candidate lines
//   start in  2  first position to scan; scanning continues start+1, ... with wrap
//   sel   out 2  first set position found (0 when vec is empty; callers must check any)
//   any   out 1  vec has at least one bit set
module prio_pick_4
  import enc_pkg::*;
(
  input  line_vec_t vec,
  input  idx_t      start,
  output idx_t      sel,
  output logic      any
);

  idx_t cand;
  logic found;

  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    any   = |vec;
    for (int k = 0; k < N_LINES; k++) begin
      // idx_t addition wraps naturally modulo 4.
      cand = start + idx_t'(k);
      if (!found && vec[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_encoder_4x2.sv
// Collects request pulses on 4 lines into a pending register and streams
// them out as 2-bit indices over a valid/ready handshake.
// Parameter:
//   RR_EN  0 = fixed priority (line 0 highest), 1 = round-robin starting after
//          the last granted index.
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   req          in   4  request pulses, one request per high bit per cycle
//   out_ready    in   1  consumer accepts out_idx when high with out_valid
//   clr_overrun  in   1  synchronous clear of the overrun flags
//   out_valid    out  1  out_idx holds a valid index
//   out_idx      out  2  encoded index (0..3 = req bit 0..3)
//   overrun      out  4  sticky: a request arrived while its line was still pending
//   busy         out  1  requests pending or output valid
module pending_encoder_4x2
  import enc_pkg::*;
#(
  parameter bit RR_EN = 1'b0
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic [3:0] overrun,
  output logic       busy
);

  line_vec_t pending_q, pending_d;
  line_vec_t overrun_q, overrun_d;
  line_vec_t clear_mask;
  logic      out_valid_q, out_valid_d;
  idx_t      out_idx_q, out_idx_d;
  idx_t      rr_ptr_q, rr_ptr_d;

  logic      load;
  logic      grant;
  idx_t      pick_start;
  idx_t      pick_sel;
  logic      pick_any;

  assign pick_start = RR_EN ? rr_ptr_q : idx_t'(0);

  prio_pick_4 u_pick (
    .vec   (pending_q),
    .start (pick_start),
    .sel   (pick_sel),
    .any   (pick_any)
  );

  // Single output stage without skid buffer: it can be refilled in the same
  // cycle the consumer takes the current index.
  assign load  = !out_valid_q || out_ready;
  assign grant = load && pick_any;

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    rr_ptr_d    = rr_ptr_q;
    clear_mask  = '0;

    if (load) begin
      if (pick_any) begin
        out_valid_d = 1'b1;
        out_idx_d   = pick_sel;
        clear_mask  = onehot(pick_sel);
        if (RR_EN) begin
          rr_ptr_d = pick_sel + idx_t'(1);
        end
      end else begin
        // Index is left at its last value; only valid drops.
        out_valid_d = 1'b0;
      end
    end

    // A request on the line being moved to the output re-pends it.
    pending_d = (pending_q & ~clear_mask) | req;

    // Set beats clear, so an overrun in the clearing cycle is not lost.
    overrun_d = (clr_overrun ? line_vec_t'(0) : overrun_q)
              | (req & pending_q & ~clear_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign overrun   = overrun_q;
  assign busy      = (pending_q != '0) || out_valid_q;

endmodule

// File: tb/tb_pending_encoder_4x2.sv
// Bench for pending_encoder_4x2: one fixed-priority and one round-robin
// instance share the same stimulus. A queue-of-lines model per instance is
// compared against the outputs on every falling edge; directed literal
// expectations pin the model at key points.
module tb_pending_encoder_4x2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic       clr_overrun;

  logic       v0, v1;
  logic [1:0] i0, i1;
  logic [3:0] ov0, ov1;
  logic       b0, b1;

  int total = 0;
  int bad   = 0;

  pending_encoder_4x2 #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .out_valid(v0), .out_idx(i0),
    .overrun(ov0), .busy(b0)
  );

  pending_encoder_4x2 #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .out_valid(v1), .out_idx(i1),
    .overrun(ov1), .busy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per mode m (0 = fixed, 1 = round-robin): set of pending lines, the
  // presented index, the overrun flags and where the next scan begins.
  bit [3:0] m_pend [2];
  bit [3:0] m_ovr  [2];
  bit       m_v    [2];
  int       m_idx  [2];
  int       m_ptr  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_ovr[m] = '0; m_v[m] = 0; m_idx[m] = 0; m_ptr[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int  g;
        bit  taken;
        g = -1;
        taken = 0;
        if (!m_v[m] || out_ready) begin
          if (m_pend[m] != 0) begin
            for (int k = 3; k >= 0; k--) begin
              int pos;
              pos = ((m == 1 ? m_ptr[m] : 0) + k) % 4;
              if (m_pend[m][pos]) g = pos;   // lowest k wins, scanned last
            end
            taken    = 1;
            m_v[m]   = 1;
            m_idx[m] = g;
            if (m == 1) m_ptr[m] = (g + 1) % 4;
          end else begin
            m_v[m] = 0;
          end
        end
        if (clr_overrun) m_ovr[m] = '0;
        for (int i = 0; i < 4; i++) begin
          if (req[i] && m_pend[m][i] && !(taken && g == i)) m_ovr[m][i] = 1;
        end
        if (taken) m_pend[m][g] = 0;
        m_pend[m] = m_pend[m] | req;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("fp_valid",   int'(v0),  int'(m_v[0]));
    check("fp_idx",     int'(i0),  m_idx[0]);
    check("fp_overrun", int'(ov0), int'(m_ovr[0]));
    check("fp_busy",    int'(b0),  int'(m_pend[0] != 0 || m_v[0]));
    check("rr_valid",   int'(v1),  int'(m_v[1]));
    check("rr_idx",     int'(i1),  m_idx[1]);
    check("rr_overrun", int'(ov1), int'(m_ovr[1]));
    check("rr_busy",    int'(b1),  int'(m_pend[1] != 0 || m_v[1]));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] r, input logic rdy, input logic clr);
    req = r; out_ready = rdy; clr_overrun = clr;
    @(negedge clk);
  endtask

  // Literal expectation on both instances; index only checked when valid.
  task automatic expect_out(input string nm, input int ev0, input int ei0,
                            input int ev1, input int ei1);
    check({nm, "_fp_v"}, int'(v0), ev0);
    if (ev0 != 0) check({nm, "_fp_i"}, int'(i0), ei0);
    check({nm, "_rr_v"}, int'(v1), ev1);
    if (ev1 != 0) check({nm, "_rr_i"}, int'(i1), ei1);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b1; clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_v", int'(v0 | v1), 0);
    check("rst_idx", int'(i0 | i1), 0);
    check("rst_ovr", int'(ov0 | ov1), 0);
    check("rst_busy", int'(b0 | b1), 0);
    #1 rst_n = 1'b1;

    // Single request on line 2: valid two edges later for one cycle.
    drive(4'b0100, 1, 0); expect_out("single_k1", 0, 0, 0, 0);
    drive(4'b0000, 1, 0); expect_out("single_k2", 1, 2, 1, 2);
    drive(4'b0000, 1, 0); expect_out("single_end", 0, 0, 0, 0);
    check("single_busy", int'(b0 | b1), 0);
    check("single_ovr", int'(ov0 | ov1), 0);

    // All four lines at once (rr pointer now 3).
    drive(4'b1111, 1, 0);
    drive(4'b0000, 1, 0); expect_out("all_0", 1, 0, 1, 3);
    drive(4'b0000, 1, 0); expect_out("all_1", 1, 1, 1, 0);
    drive(4'b0000, 1, 0); expect_out("all_2", 1, 2, 1, 1);
    drive(4'b0000, 1, 0); expect_out("all_3", 1, 3, 1, 2);
    drive(4'b0000, 1, 0); expect_out("all_end", 0, 0, 0, 0);

    // Grant line 1 (rr pointer -> 2), then 1011: rr wraps 3,0,1.
    drive(4'b0010, 1, 0);
    drive(4'b0000, 1, 0); expect_out("rr_pre", 1, 1, 1, 1);
    drive(4'b0000, 1, 0);
    drive(4'b1011, 1, 0);
    drive(4'b0000, 1, 0); expect_out("rr_0", 1, 0, 1, 3);
    drive(4'b0000, 1, 0); expect_out("rr_1", 1, 1, 1, 0);
    drive(4'b0000, 1, 0); expect_out("rr_2", 1, 3, 1, 1);
    drive(4'b0000, 1, 0); expect_out("rr_end", 0, 0, 0, 0);

    // Backpressure: index 0 held for 5 stalled cycles while line 1 arrives.
    drive(4'b0001, 1, 0);
    drive(4'b0000, 0, 0); expect_out("bp_load", 1, 0, 1, 0);
    drive(4'b0010, 0, 0); expect_out("bp_s1", 1, 0, 1, 0);
    for (int s = 0; s < 4; s++) begin
      drive(4'b0000, 0, 0); expect_out("bp_hold", 1, 0, 1, 0);
    end
    drive(4'b0000, 1, 0); expect_out("bp_next", 1, 1, 1, 1);
    drive(4'b0000, 1, 0); expect_out("bp_end", 0, 0, 0, 0);

    // Overrun on line 0 while stalled; only one index 0 comes out.
    drive(4'b0100, 1, 0);
    drive(4'b0001, 0, 0); expect_out("ov_hold", 1, 2, 1, 2);
    drive(4'b0001, 0, 0);
    check("ov_fp", int'(ov0), 1); check("ov_rr", int'(ov1), 1);
    drive(4'b0000, 1, 0); expect_out("ov_idx0", 1, 0, 1, 0);
    drive(4'b0000, 1, 0); expect_out("ov_single", 0, 0, 0, 0);

    // Clear together with a new overrun on line 3: set wins.
    drive(4'b0100, 1, 0);
    drive(4'b1000, 0, 0); expect_out("ovc_hold", 1, 2, 1, 2);
    drive(4'b1000, 0, 1);
    check("ovc_fp", int'(ov0), 8); check("ovc_rr", int'(ov1), 8);
    drive(4'b0000, 1, 0); expect_out("ovc_idx3", 1, 3, 1, 3);
    drive(4'b0000, 1, 1); expect_out("ovc_end", 0, 0, 0, 0);
    check("ovc_cleared", int'(ov0 | ov1), 0);

    // Asynchronous reset with output valid and lines 1,3 pending.
    drive(4'b0100, 1, 0);
    drive(4'b1010, 0, 0); expect_out("ar_pre", 1, 2, 1, 2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_v", int'(v0 | v1), 0);
    check("ar_idx", int'(i0 | i1), 0);
    check("ar_busy", int'(b0 | b1), 0);
    check("ar_ovr", int'(ov0 | ov1), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      drive(4'b0000, 1, 0); expect_out("ar_stale", 0, 0, 0, 0);
      check("ar_busy_after", int'(b0 | b1), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
